// File: rtl/alu_ctrl_if.sv
// Request/response handshake bundle for alu_ctrl.
// master = requester side, slave = the controller.
interface alu_ctrl_if #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CNT_W = 5
);
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [CNT_W-1:0] req_cnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_c;
    logic [WIDTH-1:0] rsp_d;

    modport master (
        output req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
        input  req_ready, rsp_valid, rsp_c, rsp_d
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_cnt, rsp_ready,
        output req_ready, rsp_valid, rsp_c, rsp_d
    );
endinterface

// File: rtl/alu_ctrl.sv
// Single-op ALU sequencer with {sign, carry, zero} status and iterated shifts/rotates.
// Define ALU_CTRL_TRAP_EN to make illegal opcodes set a sticky trap flag.
module alu_ctrl #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned CNT_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    alu_ctrl_if.slave  bus,
    output logic [2:0] status,
    output logic       busy,
    output logic       trap
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,  OP_NOT = 5'd1,  OP_AND = 5'd2,  OP_OR  = 5'd3,
        OP_XOR = 5'd4,  OP_SHR = 5'd5,  OP_SHL = 5'd6,  OP_ROR = 5'd7,
        OP_ROL = 5'd8,  OP_SWP = 5'd9,  OP_INC = 5'd10, OP_DEC = 5'd11,
        OP_ADD = 5'd12, OP_ADC = 5'd13, OP_SUB = 5'd14, OP_SBC = 5'd15,
        OP_EQ  = 5'd16, OP_GT  = 5'd17, OP_LT  = 5'd18, OP_GE  = 5'd19,
        OP_LE  = 5'd20, OP_LDSR = 5'd21, OP_XSR = 5'd22
    } op_e;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(WIDTH);

    state_t           state, state_nx;
    op_e              kind, kind_nx;
    logic [WIDTH-1:0] work, work_nx;
    logic [CNT_W-1:0] rem, rem_nx;
    logic [WIDTH-1:0] c_q, c_nx, d_q, d_nx;
    logic [2:0]       st_q, st_nx;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] step;
    logic             shout;

    function automatic logic [2:0] flags(input logic [WIDTH-1:0] r, input logic cy);
        return {r[WIDTH-1], cy, r == '0};
    endfunction

    always_comb begin
        state_nx = state;
        kind_nx  = kind;
        work_nx  = work;
        rem_nx   = rem;
        c_nx     = c_q;
        d_nx     = d_q;
        st_nx    = st_q;
        sum      = '0;
        step     = '0;
        shout    = 1'b0;
        case (state)
            IDLE: if (bus.req_valid) begin
                state_nx = DONE;
                c_nx     = '0;
                d_nx     = '0;
                case (bus.req_op)
                    OP_NOT: begin c_nx = ~bus.req_a;             st_nx = flags(c_nx, st_q[1]); end
                    OP_AND: begin c_nx = bus.req_a & bus.req_b;  st_nx = flags(c_nx, st_q[1]); end
                    OP_OR:  begin c_nx = bus.req_a | bus.req_b;  st_nx = flags(c_nx, st_q[1]); end
                    OP_XOR: begin c_nx = bus.req_a ^ bus.req_b;  st_nx = flags(c_nx, st_q[1]); end
                    OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                        if (bus.req_cnt == '0) begin
                            c_nx  = bus.req_a;
                            st_nx = flags(c_nx, st_q[1]);
                        end else begin
                            state_nx = EXEC;
                            kind_nx  = op_e'(bus.req_op);
                            work_nx  = bus.req_a;
                            rem_nx   = (bus.req_cnt > MAX_CNT) ? MAX_CNT : bus.req_cnt;
                        end
                    end
                    OP_SWP: begin c_nx = bus.req_b; d_nx = bus.req_a; end
                    OP_INC: sum = {1'b0, bus.req_a} + (WIDTH+1)'(1);
                    OP_DEC: sum = {1'b0, bus.req_a} - (WIDTH+1)'(1);
                    OP_ADD: sum = {1'b0, bus.req_a} + {1'b0, bus.req_b};
                    OP_ADC: sum = {1'b0, bus.req_a} + {1'b0, bus.req_b} + (WIDTH+1)'(st_q[1]);
                    OP_SUB: sum = {1'b0, bus.req_a} - {1'b0, bus.req_b};
                    OP_SBC: sum = {1'b0, bus.req_a} - {1'b0, bus.req_b} - (WIDTH+1)'(st_q[1]);
                    OP_EQ:  st_nx = {1'b0, st_q[1], bus.req_a == bus.req_b};
                    OP_GT:  st_nx = {bus.req_a > bus.req_b, st_q[1], 1'b0};
                    OP_LT:  st_nx = {bus.req_a < bus.req_b, st_q[1], 1'b0};
                    OP_GE:  st_nx = {bus.req_a >= bus.req_b, st_q[1], bus.req_a == bus.req_b};
                    OP_LE:  st_nx = {bus.req_a <= bus.req_b, st_q[1], bus.req_a == bus.req_b};
                    OP_LDSR: st_nx = bus.req_a[2:0];
                    OP_XSR:  st_nx = st_q ^ bus.req_a[2:0];
                    default: ;
                endcase
                // Bit WIDTH of the extended sum is carry-out for adds and borrow for subtracts.
                if (bus.req_op inside {OP_INC, OP_DEC, OP_ADD, OP_ADC, OP_SUB, OP_SBC}) begin
                    c_nx  = sum[WIDTH-1:0];
                    st_nx = flags(sum[WIDTH-1:0], sum[WIDTH]);
                end
            end
            EXEC: begin
                case (kind)
                    OP_SHR:  begin step = {1'b0, work[WIDTH-1:1]};         shout = work[0]; end
                    OP_SHL:  begin step = {work[WIDTH-2:0], 1'b0};         shout = work[WIDTH-1]; end
                    OP_ROR:  step = {work[0], work[WIDTH-1:1]};
                    default: step = {work[WIDTH-2:0], work[WIDTH-1]};
                endcase
                work_nx = step;
                rem_nx  = rem - CNT_W'(1);
                if (rem == CNT_W'(1)) begin
                    state_nx = DONE;
                    c_nx     = step;
                    st_nx    = flags(step, (kind == OP_SHR || kind == OP_SHL) ? shout : st_q[1]);
                end
            end
            DONE: if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            kind  <= OP_NOP;
            work  <= '0;
            rem   <= '0;
            c_q   <= '0;
            d_q   <= '0;
            st_q  <= '0;
        end else begin
            state <= state_nx;
            kind  <= kind_nx;
            work  <= work_nx;
            rem   <= rem_nx;
            c_q   <= c_nx;
            d_q   <= d_nx;
            st_q  <= st_nx;
        end
    end

`ifdef ALU_CTRL_TRAP_EN
    logic trap_q;
    logic illegal;

    assign illegal = (state == IDLE) && bus.req_valid && (bus.req_op > 5'd22);

    always_ff @(posedge clk) begin
        if (rst)          trap_q <= 1'b0;
        else if (illegal) trap_q <= 1'b1;
    end

    assign trap = trap_q;
`else
    assign trap = 1'b0;
`endif

    assign bus.req_ready = (state == IDLE) && !rst;
    assign bus.rsp_valid = (state == DONE);
    assign bus.rsp_c     = c_q;
    assign bus.rsp_d     = d_q;
    assign status        = st_q;
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed-vector bench for alu_ctrl; expectations are hand-computed per opcode.
module tb_alu_ctrl;
    localparam int unsigned WIDTH = 20;
    localparam int unsigned CNT_W = 5;

    localparam logic [4:0] NOP = 5'd0,  NOT = 5'd1,  AND = 5'd2,  OR  = 5'd3,  XOR = 5'd4;
    localparam logic [4:0] SHR = 5'd5,  SHL = 5'd6,  ROR = 5'd7,  SWP = 5'd9;
    localparam logic [4:0] INC = 5'd10, DEC = 5'd11, ADD = 5'd12, ADC = 5'd13, SUB = 5'd14;
    localparam logic [4:0] SBC = 5'd15, EQ  = 5'd16, GT  = 5'd17, LT  = 5'd18, GE  = 5'd19;
    localparam logic [4:0] LE  = 5'd20, LDSR = 5'd21, XSR = 5'd22, ILL = 5'd27;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] status;
    logic       busy;
    logic       trap;
    int         errors = 0;
    int         checks = 0;
    int         seen;
    logic       exp_trap;

    alu_ctrl_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    alu_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .status (status),
        .busy   (busy),
        .trap   (trap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] op,
                       input logic [19:0] a, input logic [19:0] b, input logic [4:0] cnt,
                       input logic [19:0] exp_c, input logic [19:0] exp_d,
                       input logic [2:0] exp_st, input int exp_lat, input int exp_exec);
        int lat;
        int exec;
        @(negedge clk);
        check({tag, ".ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cnt   = cnt;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat  = 1;
        exec = 0;
        while (!bus.rsp_valid && lat < 40) begin
            if (busy) exec++;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".lat"},    32'(lat),       32'(exp_lat));
        check({tag, ".exec"},   32'(exec),      32'(exp_exec));
        check({tag, ".c"},      32'(bus.rsp_c), 32'(exp_c));
        check({tag, ".d"},      32'(bus.rsp_d), 32'(exp_d));
        check({tag, ".status"}, 32'(status),    32'(exp_st));
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check({tag, ".release"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
`ifdef ALU_CTRL_TRAP_EN
        exp_trap = 1'b1;
`else
        exp_trap = 1'b0;
`endif
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cnt   = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.ready",  32'(bus.req_ready), 32'd0);
        check("rst.valid",  32'(bus.rsp_valid), 32'd0);
        check("rst.busy",   32'(busy),          32'd0);
        check("rst.status", 32'(status),        32'd0);
        check("rst.trap",   32'(trap),          32'd0);
        check("rst.c",      32'(bus.rsp_c),     32'd0);
        check("rst.d",      32'(bus.rsp_d),     32'd0);
        rst = 1'b0;
        #1;
        check("post_rst.ready", 32'(bus.req_ready), 32'd1);

        //   tag    op    a         b         cnt    c         d         st      lat exec
        run("add",  ADD,  20'hFFFFF, 20'h00001, 5'd0,  20'h00000, 20'h0, 3'b011, 1,  0);
        run("adc",  ADC,  20'hFFFFF, 20'h00005, 5'd0,  20'h00005, 20'h0, 3'b010, 1,  0);
        run("ror",  ROR,  20'h00001, 20'h0,     5'd25, 20'h00001, 20'h0, 3'b010, 21, 20);
        run("shl",  SHL,  20'h80001, 20'h0,     5'd3,  20'h00008, 20'h0, 3'b000, 4,  3);
        run("sub",  SUB,  20'h00003, 20'h00005, 5'd0,  20'hFFFFE, 20'h0, 3'b110, 1,  0);
        run("sbc",  SBC,  20'h0000A, 20'h00003, 5'd0,  20'h00006, 20'h0, 3'b000, 1,  0);
        run("dec",  DEC,  20'h00000, 20'h0,     5'd0,  20'hFFFFF, 20'h0, 3'b110, 1,  0);
        run("inc",  INC,  20'hFFFFF, 20'h0,     5'd0,  20'h00000, 20'h0, 3'b011, 1,  0);
        run("xor",  XOR,  20'hF0F0F, 20'hFFFFF, 5'd0,  20'h0F0F0, 20'h0, 3'b010, 1,  0);
        run("and",  AND,  20'h0F0F0, 20'hF0F0F, 5'd0,  20'h00000, 20'h0, 3'b011, 1,  0);
        run("not",  NOT,  20'h0000F, 20'h0,     5'd0,  20'hFFFF0, 20'h0, 3'b110, 1,  0);
        run("or",   OR,   20'h10000, 20'h00001, 5'd0,  20'h10001, 20'h0, 3'b010, 1,  0);
        run("swp",  SWP,  20'h11111, 20'h22222, 5'd0,  20'h22222, 20'h11111, 3'b010, 1, 0);
        run("shr2", SHR,  20'h00003, 20'h0,     5'd2,  20'h00000, 20'h0, 3'b011, 3,  2);
        run("shr0", SHR,  20'h80000, 20'h0,     5'd0,  20'h80000, 20'h0, 3'b110, 1,  0);

        // Backpressure: GE 5,5 held while a competing request is presented.
        @(negedge clk);
        bus.req_op = GE; bus.req_a = 20'd5; bus.req_b = 20'd5; bus.req_cnt = '0;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_op = ADD; bus.req_a = 20'hFFFFF; bus.req_b = 20'h00001;
        for (int i = 0; i < 3; i++) begin
            check("bp.valid",  32'(bus.rsp_valid), 32'd1);
            check("bp.status", 32'(status),        32'(3'b111));
            check("bp.c",      32'(bus.rsp_c),     32'd0);
            check("bp.ready",  32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("bp.release", 32'(bus.rsp_valid), 32'd0);
        check("bp.idle",    32'(bus.req_ready), 32'd1);
        check("bp.kept",    32'(status),        32'(3'b111));

        run("lt",   LT,   20'd2,     20'd7,     5'd0,  20'h0, 20'h0, 3'b110, 1, 0);
        run("gt",   GT,   20'd2,     20'd7,     5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        run("eq",   EQ,   20'd7,     20'd7,     5'd0,  20'h0, 20'h0, 3'b011, 1, 0);
        run("le",   LE,   20'd8,     20'd7,     5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        run("ldsr", LDSR, 20'h00005, 20'h0,     5'd0,  20'h0, 20'h0, 3'b101, 1, 0);
        run("xsr",  XSR,  20'h00007, 20'h0,     5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        run("nop",  NOP,  20'h12345, 20'h54321, 5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        check("pre_ill.trap", 32'(trap), 32'd0);
        run("ill",  ILL,  20'h00001, 20'h00002, 5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        check("ill.trap", 32'(trap), 32'(exp_trap));
        run("nop2", NOP,  20'h0,     20'h0,     5'd0,  20'h0, 20'h0, 3'b010, 1, 0);
        check("ill.sticky", 32'(trap), 32'(exp_trap));

        // Reset during the 4th EXEC cycle of SHR cnt=10 discards the op.
        @(negedge clk);
        bus.req_op = SHR; bus.req_a = 20'hFFFFF; bus.req_b = '0; bus.req_cnt = 5'd10;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("mid.busy",  32'(busy),          32'd1);
        check("mid.valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid.rst_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("mid.valid0", 32'(bus.rsp_valid), 32'd0);
        check("mid.status", 32'(status),        32'd0);
        check("mid.ready",  32'(bus.req_ready), 32'd1);
        check("mid.idle",   32'(busy),          32'd0);
        check("mid.trap",   32'(trap),          32'd0);
        seen = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
        end
        check("mid.no_rsp", 32'(seen), 32'd0);
        run("after", ADD, 20'h00001, 20'h00002, 5'd0, 20'h00003, 20'h0, 3'b000, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
